data_mem_pipe: RTL and testbench

DATA_MEM_PIPE -- requirements
Module: data_mem_pipe

---
 rtl/data_mem_pipe.sv | 154 +++++++++++++++
 tb/tb_data_mem_pipe.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_pipe.sv
// Byte-addressable 32-bit data memory with a valid/ready request/response handshake.
// Define DMEM_MISALIGN_TRAP_EN to reject misaligned halfword/word accesses instead of splitting them.
module data_mem_pipe #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_fun3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);
    localparam int WORDS = 2 ** (ADDR_W - 2);

    typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

    state_t              state_q, state_d;
    logic                write_q, write_d;
    logic [2:0]          fun3_q, fun3_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rd_lo_q, rd_lo_d;
    logic [31:0]         rd_hi_q, rd_hi_d;
    logic                err_q, err_d;

    // Storage relies on power-up-zero RAM; reset deliberately leaves it untouched.
    logic [3:0][7:0]     mem [WORDS];

    logic [1:0]          off;
    logic [ADDR_W-3:0]   w0, w1;
    logic [7:0]          size_mask, be;
    logic [63:0]         wide;
    logic                legal, split, we_lo, we_hi;
    logic [31:0]         ld_word;

    // Access decode: byte-enable mask and store data laid out across two adjacent words
    always_comb begin
        off  = addr_q[1:0];
        w0   = addr_q[ADDR_W-1:2];
        w1   = w0 + 1'b1;
        case (fun3_q[1:0])
            2'b00:   size_mask = 8'b0000_0001;
            2'b01:   size_mask = 8'b0000_0011;
            2'b10:   size_mask = 8'b0000_1111;
            default: size_mask = 8'b0000_0000;
        endcase
        be   = 8'(size_mask << off);
        wide = {32'b0, wdata_q} << {off, 3'b000};
        if (write_q)
            legal = (fun3_q == 3'b000) || (fun3_q == 3'b001) || (fun3_q == 3'b010);
        else
            legal = (fun3_q == 3'b000) || (fun3_q == 3'b001) || (fun3_q == 3'b010) ||
                    (fun3_q == 3'b100) || (fun3_q == 3'b101);
`ifdef DMEM_MISALIGN_TRAP_EN
        if ((fun3_q[1:0] == 2'b01 && off[0]) || (fun3_q[1:0] == 2'b10 && off != 2'b00))
            legal = 1'b0;
`endif
        split = |be[7:4];
        we_lo = (state_q == LO) && write_q && legal && !rst;
        we_hi = (state_q == HI) && write_q && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid && req_ready) state_d = LO;
            LO:      state_d = (legal && split) ? HI : RESP;
            HI:      state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        write_d = write_q;
        fun3_d  = fun3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_lo_d = rd_lo_q;
        rd_hi_d = rd_hi_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (req_valid && req_ready) begin
                write_d = req_write;
                fun3_d  = req_fun3;
                addr_d  = req_addr;
                wdata_d = req_wdata;
            end
            LO: begin
                rd_lo_d = mem[w0];
                rd_hi_d = 32'b0;
                err_d   = !legal;
            end
            HI:      rd_hi_d = mem[w1];
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            write_q <= 1'b0;
            fun3_q  <= 3'b0;
            addr_q  <= '0;
            wdata_q <= 32'b0;
            rd_lo_q <= 32'b0;
            rd_hi_q <= 32'b0;
            err_q   <= 1'b0;
        end else begin
            write_q <= write_d;
            fun3_q  <= fun3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_lo_q <= rd_lo_d;
            rd_hi_q <= rd_hi_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we_lo && be[b])     mem[w0][b] <= wide[8*b +: 8];
            if (we_hi && be[4 + b]) mem[w1][b] <= wide[32 + 8*b +: 8];
        end
    end

    always_comb begin
        req_ready = (state_q == IDLE) && !rst;
        rsp_valid = (state_q == RESP);
        rsp_err   = (state_q == RESP) && err_q;
        ld_word   = 32'({rd_hi_q, rd_lo_q} >> {off, 3'b000});
        rsp_rdata = 32'b0;
        if (state_q == RESP && !err_q && !write_q) begin
            case (fun3_q)
                3'b000:  rsp_rdata = {{24{ld_word[7]}}, ld_word[7:0]};
                3'b001:  rsp_rdata = {{16{ld_word[15]}}, ld_word[15:0]};
                3'b010:  rsp_rdata = ld_word;
                3'b100:  rsp_rdata = {24'b0, ld_word[7:0]};
                3'b101:  rsp_rdata = {16'b0, ld_word[15:0]};
                default: rsp_rdata = 32'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_pipe.sv
// Directed bench for data_mem_pipe: sizes/extension, split wrap, errors, stall and mid-op reset.
module tb_data_mem_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_fun3;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    int checks   = 0;
    int failures = 0;

    logic [31:0] rd;
    logic        er;
    int          lat;

    data_mem_pipe #(.ADDR_W(10)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_fun3(req_fun3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Starts and ends on a negedge with the DUT idle; hold>0 stalls the response that many cycles.
    task automatic txn(input string tag, input logic wr, input logic [2:0] f3,
                       input logic [9:0] a, input logic [31:0] wd, input int hold,
                       output logic [31:0] rdata, output logic err, output int latency);
        logic [31:0] snap;
        rsp_ready = (hold == 0);
        req_write = wr; req_fun3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        chk({tag, ".req_ready"}, {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        latency = 0;
        rdata = 32'b0;
        err = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            latency++;
            if (rsp_valid) break;
        end
        chk({tag, ".rsp_seen"}, {31'b0, rsp_valid}, 32'd1);
        rdata = rsp_rdata;
        err   = rsp_err;
        snap  = rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, ".stall_valid"}, {31'b0, rsp_valid}, 32'd1);
            chk({tag, ".stall_rdata"}, rsp_rdata, snap);
            chk({tag, ".stall_req_ready"}, {31'b0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_fun3 = 3'b0;
        req_addr = 10'h0; req_wdata = 32'h0; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst.req_ready", {31'b0, req_ready}, 32'd0);
        chk("rst.rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst.rsp_rdata", rsp_rdata, 32'h0);
        chk("rst.rsp_err", {31'b0, rsp_err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        txn("sw010", 1'b1, 3'b010, 10'h010, 32'h80FF1234, 0, rd, er, lat);
        chk("sw010.err", {31'b0, er}, 32'd0);
        chk("sw010.rdata", rd, 32'h0);
        chk("sw010.lat", lat, 2);
        txn("lw010", 1'b0, 3'b010, 10'h010, 32'h0, 0, rd, er, lat);
        chk("lw010.rdata", rd, 32'h80FF1234);
        chk("lw010.err", {31'b0, er}, 32'd0);
        chk("lw010.lat", lat, 2);

        txn("lb013", 1'b0, 3'b000, 10'h013, 32'h0, 0, rd, er, lat);
        chk("lb013.rdata", rd, 32'hFFFFFF80);
        txn("lbu013", 1'b0, 3'b100, 10'h013, 32'h0, 0, rd, er, lat);
        chk("lbu013.rdata", rd, 32'h00000080);
        txn("lh012", 1'b0, 3'b001, 10'h012, 32'h0, 0, rd, er, lat);
        chk("lh012.rdata", rd, 32'hFFFF80FF);
        txn("lhu012", 1'b0, 3'b101, 10'h012, 32'h0, 0, rd, er, lat);
        chk("lhu012.rdata", rd, 32'h000080FF);

`ifndef DMEM_MISALIGN_TRAP_EN
        txn("sw3fe", 1'b1, 3'b010, 10'h3FE, 32'hAABBCCDD, 0, rd, er, lat);
        chk("sw3fe.err", {31'b0, er}, 32'd0);
        chk("sw3fe.lat", lat, 3);
        txn("b3fe", 1'b0, 3'b100, 10'h3FE, 32'h0, 0, rd, er, lat);
        chk("b3fe.rdata", rd, 32'h000000DD);
        txn("b3ff", 1'b0, 3'b100, 10'h3FF, 32'h0, 0, rd, er, lat);
        chk("b3ff.rdata", rd, 32'h000000CC);
        txn("b000", 1'b0, 3'b100, 10'h000, 32'h0, 0, rd, er, lat);
        chk("b000.rdata", rd, 32'h000000BB);
        txn("b001", 1'b0, 3'b100, 10'h001, 32'h0, 0, rd, er, lat);
        chk("b001.rdata", rd, 32'h000000AA);
        txn("lw3fe", 1'b0, 3'b010, 10'h3FE, 32'h0, 0, rd, er, lat);
        chk("lw3fe.rdata", rd, 32'hAABBCCDD);
        chk("lw3fe.lat", lat, 3);
        txn("sh021", 1'b1, 3'b001, 10'h021, 32'h00001234, 0, rd, er, lat);
        chk("sh021.err", {31'b0, er}, 32'd0);
        txn("lw020", 1'b0, 3'b010, 10'h020, 32'h0, 0, rd, er, lat);
        chk("lw020.rdata", rd, 32'h00123400);
`else
        txn("sh021", 1'b1, 3'b001, 10'h021, 32'h00001234, 0, rd, er, lat);
        chk("sh021.err", {31'b0, er}, 32'd1);
        chk("sh021.rdata", rd, 32'h0);
        chk("sh021.lat", lat, 2);
        txn("lw020", 1'b0, 3'b010, 10'h020, 32'h0, 0, rd, er, lat);
        chk("lw020.rdata", rd, 32'h0);
        txn("sw3fe", 1'b1, 3'b010, 10'h3FE, 32'hAABBCCDD, 0, rd, er, lat);
        chk("sw3fe.err", {31'b0, er}, 32'd1);
        txn("lh013", 1'b0, 3'b001, 10'h013, 32'h0, 0, rd, er, lat);
        chk("lh013.err", {31'b0, er}, 32'd1);
        chk("lh013.rdata", rd, 32'h0);
`endif

        txn("ld011", 1'b0, 3'b011, 10'h010, 32'h0, 0, rd, er, lat);
        chk("ld011.err", {31'b0, er}, 32'd1);
        chk("ld011.rdata", rd, 32'h0);
        txn("sb100", 1'b1, 3'b100, 10'h010, 32'h00000055, 0, rd, er, lat);
        chk("sb100.err", {31'b0, er}, 32'd1);
        txn("lw010b", 1'b0, 3'b010, 10'h010, 32'h0, 0, rd, er, lat);
        chk("lw010b.rdata", rd, 32'h80FF1234);

        txn("stall", 1'b0, 3'b010, 10'h010, 32'h0, 5, rd, er, lat);
        chk("stall.rdata", rd, 32'h80FF1234);
        chk("stall.idle_valid", {31'b0, rsp_valid}, 32'd0);

        // Mid-operation reset: split build hits HI, trapping build hits LO of an aligned store.
        req_write = 1'b1; req_fun3 = 3'b010; req_valid = 1'b1;
`ifndef DMEM_MISALIGN_TRAP_EN
        req_addr = 10'h102; req_wdata = 32'h11223344;
`else
        req_addr = 10'h200; req_wdata = 32'hDEADBEEF;
`endif
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
`ifndef DMEM_MISALIGN_TRAP_EN
        @(negedge clk);
`endif
        chk("mrst.pre_valid", {31'b0, rsp_valid}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst.valid_in_rst", {31'b0, rsp_valid}, 32'd0);
        chk("mrst.ready_in_rst", {31'b0, req_ready}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mrst.no_rsp", {31'b0, rsp_valid}, 32'd0);
        end
`ifndef DMEM_MISALIGN_TRAP_EN
        txn("mrst.lw100", 1'b0, 3'b010, 10'h100, 32'h0, 0, rd, er, lat);
        chk("mrst.lw100.rdata", rd, 32'h33440000);
        txn("mrst.lw104", 1'b0, 3'b010, 10'h104, 32'h0, 0, rd, er, lat);
        chk("mrst.lw104.rdata", rd, 32'h0);
`else
        txn("mrst.lw200", 1'b0, 3'b010, 10'h200, 32'h0, 0, rd, er, lat);
        chk("mrst.lw200.rdata", rd, 32'h0);
`endif
        txn("mrst.lw010", 1'b0, 3'b010, 10'h010, 32'h0, 0, rd, er, lat);
        chk("mrst.lw010.rdata", rd, 32'h80FF1234);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
